// File: rtl/sva_eventually_tracker_if.sv
// Signal bundle between a req/ack producer and the unbounded-delay obligation tracker.
// Handshake: an obligation opens on a trigger built from req; any ack at least MIN_DLY cycles later discharges it.
interface sva_eventually_tracker_if #(
  parameter int unsigned CW = 16
);
  logic          req;
  logic          ack;
  logic          end_i;
  logic          pass_o;
  logic          fail_o;
  logic          pend_o;
  logic          done_o;
  logic [CW-1:0] trig_cnt;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;
  logic [CW-1:0] unres_cnt;

  modport master (
    output req, ack, end_i,
    input  pass_o, fail_o, pend_o, done_o, trig_cnt, pass_cnt, fail_cnt, unres_cnt
  );

  modport slave (
    input  req, ack, end_i,
    output pass_o, fail_o, pend_o, done_o, trig_cnt, pass_cnt, fail_cnt, unres_cnt
  );
endinterface

// File: rtl/sva_eventually_tracker.sv
// Cycle-accurate model of `trigger |-> ##[MIN_DLY:$] ack`: a MIN_DLY-deep window of young
// triggers feeds an eligible pool that one ack discharges in full, or a timeout flushes.
module sva_eventually_tracker #(
  parameter int unsigned MIN_DLY  = 1,
  parameter int unsigned MAX_WAIT = 0,
  parameter int unsigned MODE     = 0,
  parameter int unsigned CW       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  sva_eventually_tracker_if.slave bus
);

  localparam logic [CW-1:0] MIN_L = CW'(MIN_DLY);
  localparam logic [CW-1:0] MAX_W = CW'(MAX_WAIT);

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CW] ? '1 : s[CW-1:0];
  endfunction

  logic               req_q;
  logic [MIN_DLY-1:0] win_q, win_d;
  logic [CW-1:0]      pend_q, pend_d;
  logic [CW-1:0]      age_q, age_d, age_eff;
  logic [CW-1:0]      pool_in, win_pop, unres_d;
  logic               trig, leave, timeout, pass_hit;

  logic               pass_q, fail_q, pendo_q, done_q;
  logic [CW-1:0]      trig_cnt_q, pass_cnt_q, fail_cnt_q, unres_q;

  always_comb begin
    trig     = 1'b0;
    leave    = win_q[MIN_DLY-1];
    win_d    = win_q << 1;
    pool_in  = sat_add(pend_q, CW'(leave));
    age_eff  = '0;
    timeout  = 1'b0;
    pass_hit = 1'b0;
    pend_d   = pool_in;
    age_d    = '0;
    win_pop  = '0;

    if (!done_q) begin
      if (MODE == 0) trig = bus.req && !req_q;
      else           trig = bus.req && !bus.ack;
    end
    win_d[0] = trig;

    // Age is the distance from the oldest eligible trigger to the current cycle.
    if (pend_q != '0)  age_eff = sat_add(age_q, CW'(1));
    else if (leave)    age_eff = MIN_L;

    pass_hit = bus.ack && (pool_in != '0);
    timeout  = (MAX_WAIT != 0) && !bus.ack && (pool_in != '0) && (age_eff == MAX_W);
    if (bus.ack || timeout) pend_d = '0;
    if (pend_d != '0) age_d = age_eff;

    for (int i = 0; i < int'(MIN_DLY); i++) win_pop = win_pop + CW'(win_d[i]);
    unres_d = sat_add(win_pop, pend_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= 1'b0;
      win_q      <= '0;
      pend_q     <= '0;
      age_q      <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      pendo_q    <= 1'b0;
      done_q     <= 1'b0;
      trig_cnt_q <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      unres_q    <= '0;
    end else begin
      req_q   <= bus.req;
      win_q   <= win_d;
      pend_q  <= pend_d;
      age_q   <= age_d;
      pass_q  <= pass_hit;
      fail_q  <= timeout;
      pendo_q <= (win_d != '0) || (pend_d != '0);
      if (trig)     trig_cnt_q <= sat_add(trig_cnt_q, CW'(1));
      if (pass_hit) pass_cnt_q <= sat_add(pass_cnt_q, pool_in);
      if (timeout)  fail_cnt_q <= sat_add(fail_cnt_q, pool_in);
      if (bus.end_i && !done_q) begin
        unres_q <= unres_d;
        done_q  <= 1'b1;
      end
    end
  end

  assign bus.pass_o    = pass_q;
  assign bus.fail_o    = fail_q;
  assign bus.pend_o    = pendo_q;
  assign bus.done_o    = done_q;
  assign bus.trig_cnt  = trig_cnt_q;
  assign bus.pass_cnt  = pass_cnt_q;
  assign bus.fail_cnt  = fail_cnt_q;
  assign bus.unres_cnt = unres_q;

endmodule

// File: tb/tb_sva_eventually_tracker.sv
// Directed bench for sva_eventually_tracker over three parameter sets; expectations are queued
// with each stimulus step and checked one cycle later.
module tb_sva_eventually_tracker;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // A: MODE 0, MIN_DLY 1, MAX_WAIT 4.  B: MODE 0, MIN_DLY 3.  C: MODE 1, MIN_DLY 1.
  sva_eventually_tracker_if #(.CW(W)) ifa ();
  sva_eventually_tracker_if #(.CW(W)) ifb ();
  sva_eventually_tracker_if #(.CW(W)) ifc ();

  sva_eventually_tracker #(.MIN_DLY(1), .MAX_WAIT(4), .MODE(0), .CW(W)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  sva_eventually_tracker #(.MIN_DLY(3), .MAX_WAIT(0), .MODE(0), .CW(W)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  sva_eventually_tracker #(.MIN_DLY(1), .MAX_WAIT(0), .MODE(1), .CW(W)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  // Signal selectors.
  localparam int PASS_O = 0, FAIL_O = 1, PEND_O = 2, TRIG = 3, PASS = 4, FAIL = 5, UNRES = 6, DONE = 7;

  logic [W-1:0] ov [3][8];
  always_comb begin
    ov[0] = '{W'(ifa.pass_o), W'(ifa.fail_o), W'(ifa.pend_o), ifa.trig_cnt,
              ifa.pass_cnt, ifa.fail_cnt, ifa.unres_cnt, W'(ifa.done_o)};
    ov[1] = '{W'(ifb.pass_o), W'(ifb.fail_o), W'(ifb.pend_o), ifb.trig_cnt,
              ifb.pass_cnt, ifb.fail_cnt, ifb.unres_cnt, W'(ifb.done_o)};
    ov[2] = '{W'(ifc.pass_o), W'(ifc.fail_o), W'(ifc.pend_o), ifc.trig_cnt,
              ifc.pass_cnt, ifc.fail_cnt, ifc.unres_cnt, W'(ifc.done_o)};
  end

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int           inst_q[$];
  int           sig_q[$];

  function automatic string sig_name(input int s);
    case (s)
      PASS_O:  return "pass_o";
      FAIL_O:  return "fail_o";
      PEND_O:  return "pend_o";
      TRIG:    return "trig_cnt";
      PASS:    return "pass_cnt";
      FAIL:    return "fail_cnt";
      UNRES:   return "unres_cnt";
      default: return "done_o";
    endcase
  endfunction

  task automatic expect_val(input int inst, input int sig, input logic [W-1:0] v);
    exp_q.push_back(v);
    inst_q.push_back(inst);
    sig_q.push_back(sig);
  endtask

  task automatic check_all();
    logic [W-1:0] e, o;
    int           i, s;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      i = inst_q.pop_front();
      s = sig_q.pop_front();
      o = ov[i][s];
      total++;
      assert (o === e) else begin
        bad++;
        $error("FAIL %s.%s: got %0d expected %0d", (i == 0) ? "a" : (i == 1) ? "b" : "c",
               sig_name(s), o, e);
      end
    end
  endtask

  // Driver tasks
  task automatic drive(input int inst, input logic r, input logic a, input logic e);
    case (inst)
      0:       begin ifa.req = r; ifa.ack = a; ifa.end_i = e; end
      1:       begin ifb.req = r; ifb.ack = a; ifb.end_i = e; end
      default: begin ifc.req = r; ifc.ack = a; ifc.end_i = e; end
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state on every instance
    for (int i = 0; i < 3; i++)
      for (int s = 0; s < 8; s++) expect_val(i, s, '0);
    check_all();
    repeat ($urandom_range(1, 3)) cyc();

    // A: rise, fall, ack two cycles after the trigger
    drive(0, 1, 0, 0); expect_val(0, PEND_O, 1); cyc();
    drive(0, 0, 0, 0); expect_val(0, PASS_O, 0); expect_val(0, PEND_O, 1); cyc();
    drive(0, 0, 1, 0);
    expect_val(0, PASS_O, 1); expect_val(0, TRIG, 1); expect_val(0, PASS, 1);
    expect_val(0, FAIL, 0); expect_val(0, PEND_O, 0); cyc();
    drive(0, 0, 0, 0); expect_val(0, PASS_O, 0); cyc();

    // A: ack exactly MIN_DLY after the trigger
    drive(0, 1, 0, 0); cyc();
    drive(0, 0, 1, 0); expect_val(0, PASS_O, 1); expect_val(0, PASS, 2); cyc();
    drive(0, 0, 0, 0); cyc();

    // A: ack coinciding with the trigger does not discharge it; then times out at age 4
    drive(0, 1, 1, 0); expect_val(0, PASS_O, 0); expect_val(0, PEND_O, 1); cyc();
    drive(0, 0, 0, 0); expect_val(0, PASS_O, 0); expect_val(0, PEND_O, 1); expect_val(0, TRIG, 3); cyc();
    expect_val(0, FAIL_O, 0); cyc();
    expect_val(0, FAIL_O, 0); cyc();
    expect_val(0, FAIL_O, 1); expect_val(0, FAIL, 1); expect_val(0, PEND_O, 0); expect_val(0, PASS, 2); cyc();
    expect_val(0, FAIL_O, 0); cyc();

    // A: ack in the timeout cycle wins
    drive(0, 1, 0, 0); cyc();
    drive(0, 0, 0, 0); cyc();
    cyc();
    cyc();
    drive(0, 0, 1, 0);
    expect_val(0, PASS_O, 1); expect_val(0, FAIL_O, 0); expect_val(0, FAIL, 1); expect_val(0, PASS, 3); cyc();
    drive(0, 0, 0, 0); cyc();

    // B (MIN_DLY 3): triggers at b and b+2, ack held b+3..b+5
    drive(1, 1, 0, 0); cyc();
    drive(1, 0, 0, 0); cyc();
    drive(1, 1, 0, 0); cyc();
    drive(1, 0, 1, 0); expect_val(1, PASS_O, 1); expect_val(1, PASS, 1); expect_val(1, PEND_O, 1); cyc();
    expect_val(1, PASS_O, 0); expect_val(1, PASS, 1); cyc();
    expect_val(1, PASS_O, 1); expect_val(1, PASS, 2); expect_val(1, TRIG, 2); expect_val(1, PEND_O, 0); cyc();
    drive(1, 0, 0, 0); expect_val(1, PASS_O, 0); cyc();

    // C (MODE 1): three level triggers, one ack discharges all three
    drive(2, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      expect_val(2, PASS_O, 0);
      cyc();
    end
    drive(2, 1, 1, 0); expect_val(2, PASS_O, 1); expect_val(2, TRIG, 3); expect_val(2, PASS, 3); cyc();
    drive(2, 0, 0, 0); expect_val(2, PASS_O, 0); expect_val(2, PASS, 3); expect_val(2, PEND_O, 0); cyc();

    // A: end of test with two outstanding, then trigger ignored and timeout still counted
    drive(0, 1, 0, 0); cyc();
    drive(0, 0, 0, 0); cyc();
    drive(0, 1, 0, 0); cyc();
    drive(0, 0, 0, 1);
    expect_val(0, UNRES, 2); expect_val(0, DONE, 1); expect_val(0, PEND_O, 1); expect_val(0, TRIG, 6); cyc();
    drive(0, 1, 0, 0);
    expect_val(0, TRIG, 6); expect_val(0, FAIL_O, 1); expect_val(0, FAIL, 3); expect_val(0, PEND_O, 0); cyc();
    drive(0, 0, 0, 1); expect_val(0, UNRES, 2); expect_val(0, DONE, 1); expect_val(0, FAIL_O, 0); cyc();
    drive(0, 0, 0, 0);

    // Asynchronous mid-run reset
    #2;
    rst = 1'b1;
    #1;
    for (int s = 0; s < 8; s++) expect_val(0, s, '0);
    expect_val(1, TRIG, 0); expect_val(2, PASS, 0);
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expect_val(0, PASS_O, 0); expect_val(0, FAIL_O, 0); expect_val(0, DONE, 0); expect_val(0, TRIG, 0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
